// File: rtl/swap_seq_pkg.sv
// Shared constants for the swap sequencer: FSM encoding, requester count, stats widths.
package swap_seq_pkg;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SWAP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int NREQ        = 2;
    localparam int STAT_SWAP_W = 16;
    localparam int STAT_JOB_W  = 8;
endpackage

// File: rtl/swap_sequencer_if.sv
// Job request / result bundle between two requesters, a result consumer and the swap sequencer.
interface swap_sequencer_if
    import swap_seq_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 4
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ*CNT_W-1:0] req_n;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  busy;
    logic                  done_valid;
    logic                  done_ready;
    logic                  done_id;
    logic [WIDTH-1:0]      done_a;
    logic [WIDTH-1:0]      done_b;

    modport slave (
        input  req_valid, req_a, req_b, req_n, done_ready,
        output req_ready, a, b, busy, done_valid, done_id, done_a, done_b
    );

    modport master (
        output req_valid, req_a, req_b, req_n, done_ready,
        input  req_ready, a, b, busy, done_valid, done_id, done_a, done_b
    );
endinterface

// File: rtl/swap_sequencer_rr_arb2.sv
// Combinational two-way round-robin arbiter; rr selects the winner when both request.
module rr_arb2 (
    input  logic [1:0] req_valid_i,
    input  logic       rr_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);
    always_comb begin
        gnt_idx_o = 1'b0;
        case (req_valid_i)
            2'b10:   gnt_idx_o = 1'b1;
            2'b11:   gnt_idx_o = rr_i;
            default: gnt_idx_o = 1'b0;
        endcase
        gnt_o = 2'b00;
        if (|req_valid_i) gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
    end
endmodule

// File: rtl/swap_sequencer.sv
// Round-robin shared two-register exchange datapath; runs N simultaneous a/b swaps per job.
// Optional SWAP_STATS_EN adds saturating swap_total / job_total counters.
module swap_sequencer
    import swap_seq_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    swap_sequencer_if.slave        bus
`ifdef SWAP_STATS_EN
    ,
    output logic [STAT_SWAP_W-1:0] swap_total,
    output logic [STAT_JOB_W-1:0]  job_total
`endif
);
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             id_q, id_d;
    logic             rr_q, rr_d;
    logic [NREQ-1:0]  gnt;
    logic             gnt_idx;
    logic             accept;
    logic             done_hs;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [CNT_W-1:0] sel_n;

    rr_arb2 u_arb (
        .req_valid_i (bus.req_valid),
        .rr_i        (rr_q),
        .gnt_o       (gnt),
        .gnt_idx_o   (gnt_idx)
    );

    assign accept  = (state_q == S_IDLE) && (|gnt);
    assign done_hs = (state_q == S_DONE) && bus.done_ready;
    assign sel_a   = gnt_idx ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    assign sel_b   = gnt_idx ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
    assign sel_n   = gnt_idx ? bus.req_n[2*CNT_W-1:CNT_W] : bus.req_n[CNT_W-1:0];

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        rr_d    = rr_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    a_d     = sel_a;
                    b_d     = sel_b;
                    cnt_d   = sel_n;
                    id_d    = gnt_idx;
                    state_d = (sel_n != '0) ? S_SWAP : S_DONE;
                end
            end
            S_SWAP: begin
                a_d   = b_q;
                b_d   = a_q;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_DONE;
            end
            S_DONE: begin
                // Hand the next tie to whichever requester did not just finish.
                if (bus.done_ready) begin
                    state_d = S_IDLE;
                    rr_d    = ~id_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.req_ready  = (state_q == S_IDLE) ? gnt : '0;
    assign bus.a          = a_q;
    assign bus.b          = b_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.done_valid = (state_q == S_DONE);
    assign bus.done_id    = id_q;
    assign bus.done_a     = a_q;
    assign bus.done_b     = b_q;

`ifdef SWAP_STATS_EN
    logic [STAT_SWAP_W-1:0] swap_total_q;
    logic [STAT_JOB_W-1:0]  job_total_q;

    function automatic logic [STAT_SWAP_W-1:0] sat_inc_swap(input logic [STAT_SWAP_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [STAT_JOB_W-1:0] sat_inc_job(input logic [STAT_JOB_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_total_q <= '0;
            job_total_q  <= '0;
        end else begin
            if (state_q == S_SWAP) swap_total_q <= sat_inc_swap(swap_total_q);
            if (done_hs)           job_total_q  <= sat_inc_job(job_total_q);
        end
    end

    assign swap_total = swap_total_q;
    assign job_total  = job_total_q;
`else
    logic unused_done_hs;
    assign unused_done_hs = done_hs;
`endif
endmodule

// File: tb/tb_swap_sequencer.sv
// Directed bench for swap_sequencer (WIDTH=4, CNT_W=4); checks via immediate assertions.
module tb_swap_sequencer;
    localparam int WIDTH = 4;
    localparam int CNT_W = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

`ifdef SWAP_STATS_EN
    logic [15:0] swap_total;
    logic [7:0]  job_total;
`endif

    swap_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    swap_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus.slave)
`ifdef SWAP_STATS_EN
        ,
        .swap_total (swap_total),
        .job_total  (job_total)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [3:0] a0, input logic [3:0] b0,
                           input logic [3:0] n);
        bus.req_a[id*WIDTH +: WIDTH] = a0;
        bus.req_b[id*WIDTH +: WIDTH] = b0;
        bus.req_n[id*CNT_W +: CNT_W] = n;
    endtask

    // Launch one job from a single requester and walk it to DONE (not acknowledged).
    task automatic run_job(input int id, input logic [3:0] a0, input logic [3:0] b0,
                           input logic [3:0] n);
        set_req(id, a0, b0, n);
        bus.req_valid = 2'b00;
        bus.req_valid[id] = 1'b1;
        #1;
        chk("req_ready_grant", int'(bus.req_ready), (id == 0) ? 1 : 2);
        tick();
        bus.req_valid = 2'b00;
        chk("busy_after_accept", int'(bus.busy), 1);
        chk("req_ready_not_idle", int'(bus.req_ready), 0);
        for (int k = 0; k < int'(n); k++) begin
            chk("done_valid_early", int'(bus.done_valid), 0);
            chk("a_swap", int'(bus.a), (k % 2 == 1) ? int'(b0) : int'(a0));
            chk("b_swap", int'(bus.b), (k % 2 == 1) ? int'(a0) : int'(b0));
            tick();
        end
        chk("done_valid", int'(bus.done_valid), 1);
        chk("done_a", int'(bus.done_a), (n % 2 == 1) ? int'(b0) : int'(a0));
        chk("done_b", int'(bus.done_b), (n % 2 == 1) ? int'(a0) : int'(b0));
        chk("done_id", int'(bus.done_id), id);
    endtask

    task automatic ack_done();
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        chk("idle_after_ack_busy", int'(bus.busy), 0);
        chk("idle_after_ack_dv", int'(bus.done_valid), 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = 2'b00;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_n      = '0;
        bus.done_ready = 1'b0;
        #1;
        chk("reset_a", int'(bus.a), 0);
        chk("reset_busy", int'(bus.busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // Odd N from requester 0, then reset while DONE is showing
        run_job(0, 4'h3, 4'hC, 4'd3);
        chk("busy_in_done", int'(bus.busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_a", int'(bus.a), 0);
        chk("rst_mid_b", int'(bus.b), 0);
        chk("rst_mid_busy", int'(bus.busy), 0);
        chk("rst_mid_dv", int'(bus.done_valid), 0);
        chk("rst_mid_ready", int'(bus.req_ready), 0);
        #1;
        rst_n = 1'b1;
        tick();

        // Two clean jobs (n=3, n=2), then N=0
        run_job(0, 4'h3, 4'hC, 4'd3);
        ack_done();
        run_job(1, 4'h5, 4'hA, 4'd2);
        ack_done();
`ifdef SWAP_STATS_EN
        chk("swap_total", int'(swap_total), 5);
        chk("job_total", int'(job_total), 2);
`endif
        run_job(1, 4'h1, 4'h2, 4'd0);
        ack_done();

        // Both requesters held valid: grants alternate 0,1,0,1
        set_req(0, 4'h1, 4'h2, 4'd1);
        set_req(1, 4'h4, 4'h8, 4'd1);
        bus.req_valid = 2'b11;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("tie_ready", int'(bus.req_ready), (j % 2 == 0) ? 1 : 2);
            tick();
            chk("tie_ready_swap", int'(bus.req_ready), 0);
            tick();
            chk("tie_done_valid", int'(bus.done_valid), 1);
            chk("tie_done_id", int'(bus.done_id), j % 2);
            chk("tie_done_a", int'(bus.done_a), (j % 2 == 0) ? 2 : 8);
            chk("tie_ready_done", int'(bus.req_ready), 0);
            bus.done_ready = 1'b1;
            tick();
            bus.done_ready = 1'b0;
            chk("tie_idle", int'(bus.busy), 0);
        end
        bus.req_valid = 2'b00;
        tick();

        // Backpressure with requester 1 pending
        set_req(0, 4'h6, 4'h9, 4'd1);
        set_req(1, 4'h7, 4'hE, 4'd0);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b10;
        tick();
        for (int j = 0; j < 5; j++) begin
            chk("bp_done_valid", int'(bus.done_valid), 1);
            chk("bp_done_a", int'(bus.done_a), 9);
            chk("bp_done_b", int'(bus.done_b), 6);
            chk("bp_busy", int'(bus.busy), 1);
            chk("bp_no_accept", int'(bus.req_ready), 0);
            tick();
        end
        bus.done_ready = 1'b1;
        tick();
        bus.done_ready = 1'b0;
        chk("bp_idle_busy", int'(bus.busy), 0);
        chk("bp_pending_ready", int'(bus.req_ready), 2);
        tick();
        bus.req_valid = 2'b00;
        chk("bp_pending_done", int'(bus.done_valid), 1);
        chk("bp_pending_id", int'(bus.done_id), 1);
        chk("bp_pending_a", int'(bus.done_a), 7);
        ack_done();

        // Reset in the middle of a 15-swap job
        set_req(0, 4'hA, 4'h5, 4'd15);
        bus.req_valid = 2'b01;
        tick();
        bus.req_valid = 2'b00;
        repeat (4) tick();
        chk("long_busy", int'(bus.busy), 1);
        chk("long_a", int'(bus.a), 10);
        chk("long_dv", int'(bus.done_valid), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_a", int'(bus.a), 0);
        chk("abort_b", int'(bus.b), 0);
        #1;
        rst_n = 1'b1;
        for (int j = 0; j < 20; j++) begin
            tick();
            chk("abort_no_done", int'(bus.done_valid), 0);
        end
`ifdef SWAP_STATS_EN
        chk("abort_swap_total", int'(swap_total), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/swap_sequencer.md
Name: swap_sequencer

Overview:
- Controller that shares one two-register exchange datapath (registers a/b, swapped every enabled clock with non-blocking semantics) between two requesters.
- A requester hands over initial a/b values and a swap count. The block arbitrates round-robin, loads the pair, runs the requested number of exchange cycles, and returns the final a/b with the winner's ID.
- Sits between job sources and the swap register pair; the pair is instantiated inside this block.

Parameters:
- WIDTH, 1, bit width of each of a and b.
- CNT_W, 4, width of the swap-count field (max N = 2^CNT_W-1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  per-requester job valid; bit i = requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req_a  input  2*WIDTH  initial a; requester i at [i*WIDTH +: WIDTH].
- req_b  input  2*WIDTH  initial b; same packing as req_a.
- req_n  input  2*CNT_W  swap count; requester i at [i*CNT_W +: CNT_W].
- a  output  WIDTH  live register a.
- b  output  WIDTH  live register b.
- busy  output  1  high whenever state != IDLE.
- done_valid  output  1  result available.
- done_ready  input  1  result consumer accept.
- done_id  output  1  requester that owns the result.
- done_a  output  WIDTH  final a (equals a while in DONE).
- done_b  output  WIDTH  final b (equals b while in DONE).

Behaviour:
- Reset, async on rst_n low:
  - state=IDLE, a=b=0, cnt=0, done_id=0, rr pointer=0 (requester 0 preferred).
  - req_ready=0, done_valid=0, busy=0.
- FSM states IDLE, SWAP, DONE; encoding 2 bits.
- IDLE:
  - Grant goes to the single valid requester. If both are valid, the grant goes to requester rr.
  - req_ready[g]=1 combinationally for the granted requester only. It is 0 in SWAP and DONE.
  - On handshake (valid&ready): a<=req_a[g], b<=req_b[g], cnt<=req_n[g], done_id<=g.
  - Next state is SWAP if req_n[g]!=0, else DONE.
- SWAP:
  - Each cycle a<=b, b<=a (simultaneous exchange) and cnt<=cnt-1.
  - When cnt==1, the final swap is performed and the next state is DONE.
  - Exactly N exchange cycles run; odd N leaves a/b swapped, even N leaves them original.
- DONE:
  - done_valid=1 and done_a/done_b/done_id stable. a/b hold.
  - On done_ready the next state is IDLE and rr<=~done_id, so the other requester wins the next tie.
- Latency: job accepted at edge T gives done_valid high after edge T+N+1 (N=0 gives done_valid after edge T+1).
- Requester stability: req_a/req_b/req_n only need to be stable in the handshake cycle.
- Back-to-back jobs: minimum one IDLE cycle between a done handshake and the next accept. There is no bypass.
- Backpressure: done_ready low holds DONE indefinitely; requests wait and are not dropped.
- Request withdrawal: a requester dropping valid before ready is legal. Arbitration is re-evaluated every IDLE cycle.
- Reset mid-job: the job is aborted with no done_valid, and all state returns to reset values.
- cnt never underflows; cnt is 0 in IDLE and DONE.

Optional Feature:
- Macro: SWAP_STATS_EN.
- With the macro defined:
  - Extra outputs swap_total[15:0] and job_total[7:0], both reset to 0.
  - swap_total increments on every SWAP-state cycle, saturating at 16'hFFFF.
  - job_total increments on each done handshake, saturating at 8'hFF.
- Without the macro: these ports and registers are absent; core behaviour is identical.

Decomposition:
- Shared package/header swap_seq_pkg holds:
  - State constants S_IDLE=2'd0, S_SWAP=2'd1, S_DONE=2'd2.
  - Requester count NREQ=2.
  - Stats widths STAT_SWAP_W=16, STAT_JOB_W=8.
- One sub-module, rr_arb2:
  - Combinational two-way round-robin grant from req_valid and rr.
  - Outputs a grant vector and a grant index.
  - rr register stays in swap_sequencer.

Test Plan (WIDTH=4, CNT_W=4):
- Reset with outputs disturbed: assert rst_n=0 mid-cycle -> immediately a=b=0, busy=0, done_valid=0, req_ready=0.
- Single job, odd N: req0 a=4'h3, b=4'hC, n=3, done_ready=1 -> a/b toggle 3/C/3/C, done_a=C, done_b=3, done_id=0, done_valid 4 cycles after accept.
- Even N and N=0: req1 n=2 with a=5, b=A -> done 5/A. Then n=0 with a=1, b=2 -> done_valid the cycle after accept with 1/2, no SWAP cycles.
- Simultaneous requests held valid: both req_valid=1, n=1 each -> grant order 0,1,0,1. Each job accepted only in IDLE, and req_ready is never both high.
- Backpressure: done_ready=0 for 5 cycles in DONE -> done_* stable, busy=1, pending req1 not accepted until done_ready=1 and one IDLE cycle has passed.
- Reset mid-SWAP (n=15, rst_n low after 4 swaps) -> no done_valid. With SWAP_STATS_EN after two clean jobs n=3 and n=2 -> swap_total=5, job_total=2.
